// File: rtl/freq_counter_multi.sv
// Multi-channel frequency counter: per-channel edge counts over a programmable gate, snapshotted and read out bit-serially.
// Define FREQ_SATURATE_EN for saturating counters with per-channel overflow flags appended to the readout vector.
module freq_counter_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int DIV_W    = 26
) (
  input  logic                CLOCK,
  input  logic                shiftRst,
  input  logic [CHANNELS-1:0] sample,
  input  logic [DIV_W-1:0]    gate_len,
  input  logic                shift_load,
  input  logic                shift_en,
  output logic                ser_out,
  output logic                shift_busy,
  output logic                snap_valid
);

`ifdef FREQ_SATURATE_EN
  localparam int SR_W = CHANNELS * CNT_W + CHANNELS;
`else
  localparam int SR_W = CHANNELS * CNT_W;
`endif
  localparam int IDX_W = $clog2(SR_W + 1);

  logic [CHANNELS-1:0] syncA, syncB, syncPrev, edgeHit;
  logic [DIV_W-1:0]    timer, termCount;
  logic                gateEnd;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt, cntNext, snap;
  logic [SR_W-1:0]     snapVec, shreg;
  logic [IDX_W-1:0]    bitIdx;
`ifdef FREQ_SATURATE_EN
  logic [CHANNELS-1:0] ovf, ovfNext, snapOvf;
  logic [CNT_W:0]      sum;
`endif

  always_ff @(posedge CLOCK or posedge shiftRst) begin
    if (shiftRst) begin
      syncA    <= '0;
      syncB    <= '0;
      syncPrev <= '0;
    end else begin
      syncA    <= sample;
      syncB    <= syncA;
      syncPrev <= syncB;
    end
  end

  assign edgeHit = syncB & ~syncPrev;

  // termCount is refreshed on every timer-0 cycle, so a new gate_len only applies from the next window
  assign gateEnd = (timer != '0) && (timer == termCount);

  always_ff @(posedge CLOCK or posedge shiftRst) begin
    if (shiftRst) begin
      timer      <= '0;
      termCount  <= '0;
      snap_valid <= 1'b0;
    end else begin
      if (timer == '0)
        termCount <= (gate_len == '0) ? DIV_W'(1) : gate_len;
      timer      <= gateEnd ? '0 : timer + DIV_W'(1);
      snap_valid <= gateEnd;
    end
  end

  always_comb begin
    cntNext = '0;
`ifdef FREQ_SATURATE_EN
    ovfNext = '0;
    sum     = '0;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef FREQ_SATURATE_EN
      sum        = {1'b0, cnt[i]} + (CNT_W + 1)'(edgeHit[i]);
      cntNext[i] = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      ovfNext[i] = ovf[i] | sum[CNT_W];
`else
      cntNext[i] = cnt[i] + CNT_W'(edgeHit[i]);
`endif
    end
  end

  // The terminal-cycle edge goes into the snapshot, and the counter restarts from zero
  always_ff @(posedge CLOCK or posedge shiftRst) begin
    if (shiftRst) begin
      cnt  <= '0;
      snap <= '0;
`ifdef FREQ_SATURATE_EN
      ovf     <= '0;
      snapOvf <= '0;
`endif
    end else if (gateEnd) begin
      cnt  <= '0;
      snap <= cntNext;
`ifdef FREQ_SATURATE_EN
      ovf     <= '0;
      snapOvf <= ovfNext;
`endif
    end else begin
      cnt <= cntNext;
`ifdef FREQ_SATURATE_EN
      ovf <= ovfNext;
`endif
    end
  end

`ifdef FREQ_SATURATE_EN
  assign snapVec = {snapOvf, snap};
`else
  assign snapVec = snap;
`endif

  // Zeros shift in from the top, so ser_out settles at 0 once every bit has gone out
  always_ff @(posedge CLOCK or posedge shiftRst) begin
    if (shiftRst) begin
      shreg      <= '0;
      bitIdx     <= '0;
      shift_busy <= 1'b0;
    end else if (shift_load) begin
      shreg      <= snapVec;
      bitIdx     <= '0;
      shift_busy <= 1'b1;
    end else if (shift_en && shift_busy) begin
      shreg  <= shreg >> 1;
      bitIdx <= bitIdx + IDX_W'(1);
      if (bitIdx == IDX_W'(SR_W - 1))
        shift_busy <= 1'b0;
    end
  end

  assign ser_out = shreg[0];

endmodule

// File: tb/tb_freq_counter_multi.sv
// Bench for freq_counter_multi: directed scenarios plus randomized traffic against a per-window edge-count model.
module tb_freq_counter_multi;
  localparam int CHANNELS = 4;
  localparam int CNT_W    = 8;
  localparam int DIV_W    = 12;
`ifdef FREQ_SATURATE_EN
  localparam int SR_W = CHANNELS * CNT_W + CHANNELS;
`else
  localparam int SR_W = CHANNELS * CNT_W;
`endif
  localparam longint MAXC = (64'd1 << CNT_W) - 1;

  logic                CLOCK = 1'b0;
  logic                shiftRst = 1'b1;
  logic [CHANNELS-1:0] sample = '0;
  logic [DIV_W-1:0]    gate_len = '0;
  logic                shift_load = 1'b0;
  logic                shift_en = 1'b0;
  logic                ser_out, shift_busy, snap_valid;

  int nVectors = 0;
  int nMiscompares = 0;
  int cycleNo = 0;
  bit randomMode = 0;
  int halfPer [CHANNELS];

  freq_counter_multi #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .CLOCK(CLOCK), .shiftRst(shiftRst), .sample(sample), .gate_len(gate_len),
    .shift_load(shift_load), .shift_en(shift_en), .ser_out(ser_out),
    .shift_busy(shift_busy), .snap_valid(snap_valid)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference model: edges seen after the synchroniser latency, summed per window
  logic [CHANNELS-1:0] h0 = '0, h1 = '0, h2 = '0;
  longint accum [CHANNELS];
  logic [SR_W-1:0] mSnapVec = '0, rdVec = '0;
  int rdIdx = 0, wPos = 0, wLen = 2;
  bit rdBusy = 0, mValid = 0;

  always @(posedge CLOCK or posedge shiftRst) begin
    if (shiftRst) begin
      h0 = '0; h1 = '0; h2 = '0;
      for (int i = 0; i < CHANNELS; i++) accum[i] = 0;
      mSnapVec = '0; rdVec = '0; rdIdx = 0; rdBusy = 0; mValid = 0; wPos = 0;
    end else begin
      if (shift_load) begin
        rdVec = mSnapVec; rdIdx = 0; rdBusy = 1;
      end else if (shift_en && rdBusy) begin
        rdIdx++;
        if (rdIdx == SR_W) rdBusy = 0;
      end
      for (int i = 0; i < CHANNELS; i++) if (h1[i] && !h2[i]) accum[i]++;
      h2 = h1; h1 = h0; h0 = sample;
      if (wPos == 0) wLen = ((gate_len == 0) ? 1 : int'(gate_len)) + 1;
      mValid = (wPos == wLen - 1);
      if (mValid) begin
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef FREQ_SATURATE_EN
          mSnapVec[i*CNT_W +: CNT_W] = CNT_W'((accum[i] > MAXC) ? MAXC : accum[i]);
          mSnapVec[CHANNELS*CNT_W + i] = (accum[i] > MAXC);
`else
          mSnapVec[i*CNT_W +: CNT_W] = CNT_W'(accum[i] % (MAXC + 1));
`endif
          accum[i] = 0;
        end
        wPos = 0;
      end else begin
        wPos++;
      end
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge CLOCK) begin
    checkOutput("ser_out", longint'(ser_out), longint'(rdBusy ? rdVec[rdIdx] : 1'b0));
    checkOutput("shift_busy", longint'(shift_busy), longint'(rdBusy));
    checkOutput("snap_valid", longint'(snap_valid), longint'(mValid));
  end

  task automatic tick();
    @(negedge CLOCK);
    #1;
    cycleNo++;
    if (randomMode) begin
      if (cycleNo % 2 == 0) sample = CHANNELS'($urandom);
      shift_load = ($urandom_range(0, 11) == 0);
      shift_en   = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 63) == 0) gate_len = DIV_W'($urandom_range(0, 15));
      shiftRst   = ($urandom_range(0, 399) == 0);
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        if (halfPer[i] != 0 && cycleNo % halfPer[i] == 0) sample[i] = ~sample[i];
    end
  endtask

  task automatic applyStimulus(input int gl, input int p0, input int p1, input int p2, input int p3);
    shiftRst = 1'b1; shift_load = 1'b0; shift_en = 1'b0;
    sample = '0; gate_len = DIV_W'(gl);
    halfPer[0] = p0; halfPer[1] = p1; halfPer[2] = p2; halfPer[3] = p3;
    tick(); tick();
    cycleNo = 0;
    shiftRst = 1'b0;
  endtask

  task automatic waitSnap(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!snap_valid && n < limit);
    if (!snap_valid) begin
      nVectors++; nMiscompares++;
      $display("[TB] FAIL snapTimeout: no snap_valid within %0d cycles, expected a pulse", limit);
    end
  endtask

  task automatic readout(output logic [SR_W-1:0] v);
    v = '0;
    shift_load = 1'b1; shift_en = 1'b0;
    tick();
    shift_load = 1'b0;
    tick();
    for (int j = 0; j < SR_W; j++) begin
      v[j] = ser_out;
      shift_en = 1'b1;
      tick();
    end
    shift_en = 1'b0;
    checkOutput("busyAfterLastBit", longint'(shift_busy), 0);
    checkOutput("serAfterLastBit", longint'(ser_out), 0);
  endtask

  initial begin
    logic [SR_W-1:0] vec;
    int n;
    for (int i = 0; i < CHANNELS; i++) halfPer[i] = 0;
    tick(); tick();
    checkOutput("resetSer", longint'(ser_out), 0);
    checkOutput("resetBusy", longint'(shift_busy), 0);
    checkOutput("resetValid", longint'(snap_valid), 0);

    $display("[TB] gate_len=9, channel 0 period 10");
    applyStimulus(9, 5, 0, 0, 0);
    for (int k = 0; k < 3; k++) waitSnap(40, n);
    waitSnap(40, n);
    checkOutput("snapInterval", n, 10);
    readout(vec);
    checkOutput("gate9Ch0", longint'(vec[0 +: CNT_W]), 1);
    for (int i = 1; i < CHANNELS; i++)
      checkOutput("gate9Other", longint'(vec[i*CNT_W +: CNT_W]), 0);

    $display("[TB] gate_len=99, channel 1 period 4");
    applyStimulus(99, 0, 2, 0, 0);
    waitSnap(300, n);
    waitSnap(300, n);
    readout(vec);
    checkOutput("gate99Ch1", longint'(vec[CNT_W +: CNT_W]), 25);
    checkOutput("gate99Ch0", longint'(vec[0 +: CNT_W]), 0);

    $display("[TB] 300 edges per window on channel 2");
    applyStimulus(1199, 0, 0, 2, 0);
    waitSnap(2500, n);
    waitSnap(2500, n);
    readout(vec);
`ifdef FREQ_SATURATE_EN
    checkOutput("satCount", longint'(vec[2*CNT_W +: CNT_W]), 255);
    checkOutput("satOvf", longint'(vec[CHANNELS*CNT_W + 2]), 1);
`else
    checkOutput("wrapCount", longint'(vec[2*CNT_W +: CNT_W]), 44);
`endif

    $display("[TB] reset during readout");
    shift_load = 1'b1;
    tick();
    shift_load = 1'b0; shift_en = 1'b1;
    for (int j = 0; j < 18; j++) tick();
    shift_en = 1'b0;
    checkOutput("midReadoutSer", longint'(ser_out), 1);
    shiftRst = 1'b1;
    #1;
    checkOutput("asyncRstSer", longint'(ser_out), 0);
    checkOutput("asyncRstBusy", longint'(shift_busy), 0);
    tick();
    shiftRst = 1'b0;
    tick();
    readout(vec);
    checkOutput("snapAfterReset", longint'(vec), 0);

    $display("[TB] randomized traffic");
    gate_len = DIV_W'(5);
    randomMode = 1;
    for (int k = 0; k < 3000; k++) tick();
    randomMode = 0;
    shiftRst = 1'b0; shift_load = 1'b0; shift_en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end
endmodule
